port_in_param: RTL and testbench
================================

# port_in_param

Parametrised router input port for the N×N crosspoint switch. Deserialises an LSB-first destination address from the serial input stream, raises a one-hot request to the target output port, and waits for a grant. On grant it forwards frame, valid and data to that lane; if the grant does not arrive within a set time it drops the packet. Inactive lanes drive idle levels with an explicit enable vector instead of tristates. A delivered-packet counter is provided. The block sits between a serial source and the per-output arbiters/muxes.

## Interface
- ADDR_W, 4, destination address width; NUM_PORTS = 2**ADDR_W (derived localparam)
- GRANT_TIMEOUT, 64, max WAIT cycles before drop; 0 disables timeout
- TO_W, 8, timeout counter width; GRANT_TIMEOUT < 2**TO_W required
- CNT_W, 16, delivered-packet counter width
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- busy_in  in  NUM_PORTS  output port i busy
- grant  in  NUM_PORTS  output port i granted to this input
- frame_n  in  1  active-low frame
- valid_n  in  1  active-low valid
- din  in  1  serial data
- request  out  NUM_PORTS  one-hot request to destination
- oe  out  NUM_PORTS  one-hot lane enable, high only in PAYLOAD
- frameo_n  out  NUM_PORTS  per-lane frame; idle lanes = 1
- valido_n  out  NUM_PORTS  per-lane valid; idle lanes = 1
- dout  out  NUM_PORTS  per-lane data; idle lanes = 0
- port_busy  out  1  state != IDLE
- drop_pulse  out  1  one-cycle pulse on timeout drop
- abort_pulse  out  1  one-cycle pulse on early frame end (ADDR/WAIT)
- pkt_count  out  CNT_W  delivered packets, wraps

## Operation
- States: IDLE, ADDR, WAIT, PAYLOAD, DROP. addr register ADDR_W bits; bit counter; timeout counter TO_W bits.
- IDLE: if frame_n==0 → addr[0]<=din, bit cnt<=1, go to ADDR. Otherwise stay.
- ADDR: if frame_n==1 → IDLE, abort_pulse. Otherwise addr[cnt]<=din and cnt++. When the captured bit is ADDR_W-1 → WAIT, timer<=0. ADDR_W==1 goes IDLE→WAIT directly.
- WAIT: request[addr]=1. Checks in priority order:
  - frame_n==1 → IDLE, abort_pulse.
  - grant[addr] && !busy_in[addr] → PAYLOAD.
  - GRANT_TIMEOUT!=0 && timer==GRANT_TIMEOUT-1 → DROP, drop_pulse.
  - Otherwise timer++.
- PAYLOAD: request[addr]=1, oe[addr]=1. Lane addr combinationally carries frame_n/valid_n/din. When frame_n==1 (last bit, still forwarded that cycle) → IDLE and pkt_count++ (wraps mod 2**CNT_W).
- DROP: no request, all lanes idle. Input is discarded until frame_n==1 → IDLE.
- Grant or busy changes during PAYLOAD are ignored; the lane stays until frame end.
- Leaving any state to IDLE clears addr, the bit count and the timer.

## Timing
- Reset (async assert, sync deassert at next edge): state IDLE, request 0, oe 0, frameo_n all 1, valido_n all 1, dout all 0, port_busy 0, drop_pulse 0, abort_pulse 0, pkt_count 0. Reset during PAYLOAD kills forwarding immediately.
- request is registered-state decoded. It asserts the cycle after the edge that captures the last address bit, i.e. ADDR_W cycles after frame_n first seen low.
- Grant latency: grant&!busy sampled at edge k → oe/forwarding from cycle k+1. Forwarding has zero latency (combinational) from the inputs.
- request/oe drop the cycle after the edge where frame_n==1 is sampled in PAYLOAD.
- Timeout: drop occurs at the edge ending the GRANT_TIMEOUT-th WAIT cycle. drop_pulse is high for exactly the following cycle.
- Pulses are registered and last one cycle. abort and drop never occur together.
- A new frame (frame_n low) in the IDLE cycle right after PAYLOAD/DROP is accepted back-to-back.

## Test plan
- ADDR_W=4: frame_n low, din bits 1,0,1,1 (addr=13) → request=16'h2000 from cycle 5. grant[13]=1, busy_in=0 → oe=16'h2000 next cycle, dout[13] follows din, other lanes 0/1/1. frame_n high → pkt_count=1.
- busy_in[13]=1 with grant[13]=1 for 3 cycles, then busy clears → stays in WAIT, request held, oe=0 until the cycle after busy clears.
- GRANT_TIMEOUT=4, no grant → drop_pulse on the 5th cycle after request rises, request=0, outputs idle. frame_n high → IDLE, pkt_count unchanged.
- frame_n high after 2 address bits → abort_pulse one cycle, no request ever asserted, next frame addr=2 routes to lane 2.
- reset_n low mid-PAYLOAD → all outputs at reset values in the same cycle, pkt_count=0.
- CNT_W=2: 5 delivered packets → pkt_count=1 (wrap). Back-to-back frames with one idle cycle are both delivered.

Source files
------------

// File: rtl/port_in_param.sv
// Router input port: deserialises an LSB-first destination address, requests the
// target output lane, forwards the frame once granted, and drops it on grant timeout.
module port_in_param #(
  parameter int ADDR_W        = 4,
  parameter int GRANT_TIMEOUT = 64,
  parameter int TO_W          = 8,
  parameter int CNT_W         = 16,
  localparam int NUM_PORTS    = 2**ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] busy_in,
  input  logic [NUM_PORTS-1:0] grant,
  input  logic                 frame_n,
  input  logic                 valid_n,
  input  logic                 din,
  output logic [NUM_PORTS-1:0] request,
  output logic [NUM_PORTS-1:0] oe,
  output logic [NUM_PORTS-1:0] frameo_n,
  output logic [NUM_PORTS-1:0] valido_n,
  output logic [NUM_PORTS-1:0] dout,
  output logic                 port_busy,
  output logic                 drop_pulse,
  output logic                 abort_pulse,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int CNT_BW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam logic [CNT_BW-1:0] LAST_BIT = CNT_BW'(ADDR_W - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'((GRANT_TIMEOUT == 0) ? 0 : GRANT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_PAYLOAD,
    ST_DROP
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic               drop_pulse_q, drop_pulse_d;
  logic               abort_pulse_q, abort_pulse_d;
  logic [NUM_PORTS-1:0] lane_sel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      pkt_count_q   <= '0;
      drop_pulse_q  <= 1'b0;
      abort_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      pkt_count_q   <= pkt_count_d;
      drop_pulse_q  <= drop_pulse_d;
      abort_pulse_q <= abort_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    pkt_count_d   = pkt_count_q;
    drop_pulse_d  = 1'b0;
    abort_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!frame_n) begin
          addr_d    = '0;
          addr_d[0] = din;
          cnt_d     = CNT_BW'(1);
          timer_d   = '0;
          state_d   = (ADDR_W == 1) ? ST_WAIT : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (frame_n) begin
          state_d       = ST_IDLE;
          abort_pulse_d = 1'b1;
        end else begin
          addr_d[cnt_q] = din;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_WAIT;
            timer_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_BW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (frame_n) begin
          state_d       = ST_IDLE;
          abort_pulse_d = 1'b1;
        end else if (grant[addr_q] && !busy_in[addr_q]) begin
          state_d = ST_PAYLOAD;
        end else if (GRANT_TIMEOUT != 0 && timer_q == TO_LAST) begin
          state_d      = ST_DROP;
          drop_pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      ST_PAYLOAD: begin
        // The frame_n-high cycle is still forwarded; the packet counts as delivered here.
        if (frame_n) begin
          state_d     = ST_IDLE;
          pkt_count_d = pkt_count_q + CNT_W'(1);
        end
      end
      ST_DROP: begin
        if (frame_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      addr_d  = '0;
      cnt_d   = '0;
      timer_d = '0;
    end
  end

  // Idle lanes are held at frame/valid high and data low rather than tristated.
  always_comb begin
    lane_sel  = NUM_PORTS'(1) << addr_q;
    request   = '0;
    oe        = '0;
    frameo_n  = '1;
    valido_n  = '1;
    dout      = '0;
    port_busy = (state_q != ST_IDLE);
    case (state_q)
      ST_WAIT: request = lane_sel;
      ST_PAYLOAD: begin
        request          = lane_sel;
        oe               = lane_sel;
        frameo_n[addr_q] = frame_n;
        valido_n[addr_q] = valid_n;
        dout[addr_q]     = din;
      end
      default: ;
    endcase
  end

  assign drop_pulse  = drop_pulse_q;
  assign abort_pulse = abort_pulse_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_port_in_param.sv
// Bench for port_in_param: table-driven packets, a mid-payload reset, and random
// packets checked cycle by cycle against a packet-level reference model.
module tb_port_in_param;

  localparam int ADDR_W        = 4;
  localparam int NUM_PORTS     = 16;
  localparam int GRANT_TIMEOUT = 4;
  localparam int TO_W          = 8;
  localparam int CNT_W         = 2;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NUM_PORTS-1:0] busy_in, grant;
  logic                 frame_n, valid_n, din;
  logic [NUM_PORTS-1:0] request, oe, frameo_n, valido_n, dout;
  logic                 port_busy, drop_pulse, abort_pulse;
  logic [CNT_W-1:0]     pkt_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int model_cnt = 0;
  bit pend_abort = 1'b0;
  bit pend_drop = 1'b0;

  typedef enum int {M_IDLE, M_ADDR, M_WAIT, M_PAY, M_DROP} mode_e;

  typedef struct {
    logic [3:0] addr;
    int         abort_bits;
    int         busy_cyc;
    int         grant_dly;
    int         pay_len;
    int         drop_len;
    int         gap;
    int         exp_count;
  } vec_t;

  port_in_param #(
    .ADDR_W(ADDR_W), .GRANT_TIMEOUT(GRANT_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .busy_in(busy_in), .grant(grant),
    .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .request(request), .oe(oe), .frameo_n(frameo_n), .valido_n(valido_n), .dout(dout),
    .port_busy(port_busy), .drop_pulse(drop_pulse), .abort_pulse(abort_pulse),
    .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  task automatic applyStimulus(input logic f, input logic v, input logic d,
                               input logic [15:0] g, input logic [15:0] b);
    frame_n = f;
    valid_n = v;
    din     = d;
    grant   = g;
    busy_in = b;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    cmp({tag, ".request"},  32'(request),     32'h0);
    cmp({tag, ".oe"},       32'(oe),          32'h0);
    cmp({tag, ".frameo_n"}, 32'(frameo_n),    32'hffff);
    cmp({tag, ".valido_n"}, 32'(valido_n),    32'hffff);
    cmp({tag, ".dout"},     32'(dout),        32'h0);
    cmp({tag, ".busy"},     32'(port_busy),   32'h0);
    cmp({tag, ".drop"},     32'(drop_pulse),  32'h0);
    cmp({tag, ".abort"},    32'(abort_pulse), 32'h0);
    cmp({tag, ".count"},    32'(pkt_count),   32'h0);
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, returns at next posedge+1.
  task automatic checkOutput(input string tag, input mode_e m, input logic [3:0] a);
    logic [15:0] oh, e_req, e_oe, e_fr, e_va, e_do;
    oh    = 16'h1 << a;
    e_req = (m == M_WAIT || m == M_PAY) ? oh : 16'h0;
    e_oe  = (m == M_PAY) ? oh : 16'h0;
    e_fr  = 16'hffff;
    e_va  = 16'hffff;
    e_do  = 16'h0;
    if (m == M_PAY) begin
      e_fr[a] = frame_n;
      e_va[a] = valid_n;
      e_do[a] = din;
    end
    @(negedge clock);
    cmp({tag, ".request"},  32'(request),     32'(e_req));
    cmp({tag, ".oe"},       32'(oe),          32'(e_oe));
    cmp({tag, ".frameo_n"}, 32'(frameo_n),    32'(e_fr));
    cmp({tag, ".valido_n"}, 32'(valido_n),    32'(e_va));
    cmp({tag, ".dout"},     32'(dout),        32'(e_do));
    cmp({tag, ".busy"},     32'(port_busy),   32'(m != M_IDLE));
    cmp({tag, ".drop"},     32'(drop_pulse),  32'(pend_drop));
    cmp({tag, ".abort"},    32'(abort_pulse), 32'(pend_abort));
    cmp({tag, ".count"},    32'(pkt_count),   32'(exp_cnt % 4));
    pend_drop  = 1'b0;
    pend_abort = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic runPacket(input logic [3:0] a, input int abort_bits, input int busy_cyc,
                           input int grant_dly, input int pay_len, input int drop_len,
                           input int gap);
    logic [15:0] g, b;
    bit aborted, granted;
    int w;
    aborted = 1'b0;
    granted = 1'b0;
    for (int i = 0; i < ADDR_W && !aborted; i++) begin
      if (i == abort_bits) begin
        applyStimulus(1'b1, 1'b1, 1'b0, rnd16(), rnd16());
        checkOutput("abort", M_ADDR, a);
        pend_abort = 1'b1;
        aborted    = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'($urandom), a[i], rnd16(), rnd16());
        checkOutput("addr", (i == 0) ? M_IDLE : M_ADDR, a);
      end
    end
    if (!aborted) begin
      w = 0;
      while (1) begin
        g = rnd16();
        b = rnd16();
        g[a] = (w >= grant_dly);
        b[a] = (w < busy_cyc);
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), g, b);
        checkOutput("wait", M_WAIT, a);
        if (g[a] && !b[a]) begin
          granted = 1'b1;
          break;
        end
        if (w == GRANT_TIMEOUT - 1) begin
          pend_drop = 1'b1;
          break;
        end
        w++;
      end
      if (granted) begin
        for (int p = 0; p < pay_len; p++) begin
          applyStimulus(p == pay_len - 1, 1'($urandom), 1'($urandom), rnd16(), rnd16());
          checkOutput("payload", M_PAY, a);
        end
        exp_cnt++;
      end else begin
        for (int d = 0; d <= drop_len; d++) begin
          applyStimulus(d == drop_len, 1'($urandom), 1'($urandom), rnd16(), rnd16());
          checkOutput("drop", M_DROP, a);
        end
      end
    end
    for (int k = 0; k < gap; k++) begin
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), rnd16(), rnd16());
      checkOutput("idle", M_IDLE, a);
    end
  endtask

  initial begin
    vec_t vecs[7];
    logic [15:0] g;
    logic [3:0]  ra;
    int          rab, rbusy, rgnt;

    // addr, abort_bits (ADDR_W = none), busy, grant delay, payload, drop len, gap, count
    vecs[0] = '{4'd13, 4, 0, 0, 3, 1, 1, 1};
    vecs[1] = '{4'd13, 4, 3, 0, 2, 1, 1, 2};
    vecs[2] = '{4'd7,  4, 0, 9, 2, 2, 1, 2};
    vecs[3] = '{4'd0,  2, 0, 0, 2, 1, 0, 2};
    vecs[4] = '{4'd2,  4, 0, 3, 1, 1, 0, 3};
    vecs[5] = '{4'd15, 4, 0, 1, 4, 1, 0, 4};
    vecs[6] = '{4'd2,  4, 0, 0, 2, 1, 1, 5};

    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkResetValues("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    checkOutput("post_reset", M_IDLE, 4'd0);

    for (int v = 0; v < 7; v++) begin
      runPacket(vecs[v].addr, vecs[v].abort_bits, vecs[v].busy_cyc, vecs[v].grant_dly,
                vecs[v].pay_len, vecs[v].drop_len, vecs[v].gap);
      cmp($sformatf("table%0d.count", v), 32'(pkt_count), 32'(vecs[v].exp_count % 4));
    end

    // Reset asserted in the middle of a payload must idle every lane immediately.
    for (int i = 0; i < ADDR_W; i++) begin
      ra = 4'd9;
      applyStimulus(1'b0, 1'b1, ra[i], 16'h0, 16'h0);
      checkOutput("rst.addr", (i == 0) ? M_IDLE : M_ADDR, 4'd9);
    end
    g = 16'h0;
    g[9] = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, g, 16'h0);
    checkOutput("rst.wait", M_WAIT, 4'd9);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("rst.pay", M_PAY, 4'd9);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("rst.mid");
    exp_cnt    = 0;
    pend_drop  = 1'b0;
    pend_abort = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    checkOutput("rst.after", M_IDLE, 4'd0);

    // Packet-level model: aborted if frame ends mid-address, delivered if grant
    // with a free lane arrives within the timeout window, dropped otherwise.
    model_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      ra    = 4'($urandom);
      rab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ADDR_W - 1) : ADDR_W;
      rbusy = $urandom_range(0, 5);
      rgnt  = $urandom_range(0, 6);
      runPacket(ra, rab, rbusy, rgnt, $urandom_range(1, 5), $urandom_range(0, 2),
                $urandom_range(0, 2));
      if (rab >= ADDR_W && ((rgnt > rbusy) ? rgnt : rbusy) < GRANT_TIMEOUT) model_cnt++;
      cmp($sformatf("rand%0d.count", n), 32'(pkt_count), 32'(model_cnt % 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
